// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive/transmit blocks.
//   rx_state_t      - receive sequencer states
//   UART_DATA_BITS  - data bits per frame
//   odd_parity_err  - 1 when data plus parity bit do not contain an odd
//                     number of ones
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic logic odd_parity_err(input logic [UART_DATA_BITS-1:0] data,
                                          input logic                      pbit);
    return ~(^{data, pbit});
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous level input.
// Both flops reset to 1 so an idle-high serial line (or deasserted CTS)
// reads as idle out of reset.
//   clk   - destination clock
//   reset - asynchronous, active-high
//   d     - asynchronous input
//   q     - synchronised output
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: flops are written with non-blocking assignments so meta->q
  // behaves as a real two-stage shift regardless of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer.
// Oversamples the synchronised line, validates the start bit, and issues
// one-cycle mid-bit strobes to the external SIPO/parity/stop datapath. A
// shadow byte is assembled internally, checked for odd parity and a valid
// stop bit, and offered on a valid/ready port.
//   clk, reset                      - clock, async active-high reset
//   rx_in                           - raw serial line, idle high
//   shift, check_parity, check_stop - mid-bit strobes to the datapath
//   busy                            - sequencer not idle
//   data_out, out_parity_err        - received byte and its parity status
//   out_valid / out_ready           - output handshake
//   framing_error                   - stop bit sampled low (pulse)
//   overrun                         - good frame dropped, output full (pulse)
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_in,
  output logic                      shift,
  output logic                      check_parity,
  output logic                      check_stop,
  output logic                      busy,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_parity_err,
  output logic                      framing_error,
  output logic                      overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                idx;
  logic [UART_DATA_BITS-1:0] shadow;
  logic                      perr_q;
  logic                      commit_pend;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

  assign busy = (state != ST_IDLE);

  // Sequencer. Strobes default low so each is a single-cycle pulse.
  // NOTE: the shadow byte is a plain register, not a memory, so it is
  // cleared by reset along with the rest of the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      idx           <= '0;
      shadow        <= '0;
      perr_q        <= 1'b0;
      commit_pend   <= 1'b0;
      shift         <= 1'b0;
      check_parity  <= 1'b0;
      check_stop    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      shift         <= 1'b0;
      check_parity  <= 1'b0;
      check_stop    <= 1'b0;
      framing_error <= 1'b0;
      commit_pend   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            idx <= '0;
            // A line back high at mid start bit was only a glitch.
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == FULL_M1) begin
            cnt         <= '0;
            shift       <= 1'b1;
            shadow[idx] <= rx_s;
            if (idx == IDX_LAST) begin
              state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (cnt == FULL_M1) begin
            cnt          <= '0;
            check_parity <= 1'b1;
            perr_q       <= odd_parity_err(shadow, rx_s);
            state        <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            check_stop <= 1'b1;
            if (rx_s) begin
              commit_pend <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          // Wait for the line to recover so a held-low line never retriggers.
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register. A commit in the same cycle as a transfer
  // replaces the byte and keeps out_valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out       <= '0;
      out_parity_err <= 1'b0;
      out_valid      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit_pend) begin
        if (!out_valid || out_ready) begin
          data_out       <= shadow;
          out_parity_err <= perr_q;
          out_valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for the UART: synchronises and oversamples `rx_in`, validates the start bit, and issues mid-bit strobes (`shift`, `check_parity`, `check_stop`) to the SIPO/parity/stop datapath. It also keeps a shadow copy of each byte and checks odd parity and the stop bit itself. Completed bytes go out on a valid/ready port with parity, framing and overrun status.

## Interface
- `CLKS_PER_BIT`, 16: clocks per bit period; legal range is 4 or more.
- `PARITY_EN`, 1: 1 = one odd-parity bit follows the data; 0 = no parity bit.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `rx_in` in 1: raw serial line; idle high.
- `shift` out 1: 1-cycle pulse at the centre of each data bit (8 per frame).
- `check_parity` out 1: 1-cycle pulse at the centre of the parity bit.
- `check_stop` out 1: 1-cycle pulse at the centre of the stop bit.
- `busy` out 1: high whenever state ≠ IDLE.
- `data_out` out 8: received byte, LSB-first assembled.
- `out_valid` out 1: byte available.
- `out_ready` in 1: consumer accepts; transfer occurs when `out_valid && out_ready`.
- `out_parity_err` out 1: parity status of the byte on `data_out`.
- `framing_error` out 1: 1-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: 1-cycle pulse when a good frame is dropped.

## Operation
- `rx_in` passes through a 2-flop synchroniser giving `rx_s`. Both flops reset to 1.
- States are IDLE, START, DATA, PARITY, STOP, BREAK.
- Single bit counter `cnt` and bit index `idx` (0–7).
- IDLE: if `rx_s`=0, go to START with `cnt`=0.
- START: at `cnt`=CLKS_PER_BIT/2−1, sample `rx_s`.
  - If 0: go to DATA with `cnt`=0 and `idx`=0.
  - If 1: glitch; return to IDLE with no strobe and no flag.
- DATA: at `cnt`=CLKS_PER_BIT−1, pulse `shift` and load `rx_s` into shadow bit `idx`.
  - After `idx`=7, go to PARITY if PARITY_EN, else STOP.
- PARITY: at the terminal count, pulse `check_parity`.
  - Parity error = XOR(shadow byte, `rx_s`) == 0 (odd parity).
- STOP: at the terminal count, pulse `check_stop`.
  - If `rx_s`=1, commit the frame and go to IDLE.
  - If `rx_s`=0, pulse `framing_error`, discard the byte and go to BREAK.
- BREAK: stay until `rx_s`=1, then go to IDLE. A held-low line never retriggers.
- Commit:
  - If `out_valid` is 0, or `out_ready` is 1 in the commit cycle: load `data_out`/`out_parity_err`; `out_valid` becomes 1.
  - Otherwise keep the old byte, pulse `overrun` and drop the new one.
- Handshake: `out_valid` stays high until accepted; it drops the cycle after the transfer unless a commit coincides.
- Reset mid-frame returns to IDLE immediately; no strobe or flag may follow.
- Reset values:
  - State IDLE; `cnt`, `idx` and shadow all 0.
  - All outputs 0, including `data_out` and `out_parity_err`.

## Timing
- Cycle 0 is the first rising edge at which `rx_in`=0 is sampled.
- `rx_s` is low at cycle 2; START is entered at cycle 3.
- Start bit is checked at cycle 3+CLKS_PER_BIT/2−1.
- Data bit k centre is CLKS_PER_BIT·(k+1) cycles after the start check.
- For CLKS_PER_BIT=16:
  - Start check at cycle 10.
  - `shift` at cycles 26+16k.
  - `check_parity` at 154.
  - `check_stop` at 170, or 154 with PARITY_EN=0.
  - `out_valid` is high from cycle 171 (155 without parity).
- Strobes are registered and high exactly one cycle. They are never simultaneous.
- A new start bit is recognised from the cycle after the stop sample, so back-to-back frames are allowed.

## Structure
- Package `uart_pkg`: state enum `rx_state_t`, `UART_DATA_BITS`=8, odd-parity helper function.
- Sub-module `uart_sync2`: 2-flop synchroniser, reset-to-1. Reusable on the TX side for CTS.
- The datapath modules are not instantiated here. The top level wires the strobes to them.

## Test plan
- Frame 0xA5, parity bit 1, stop 1, `out_ready`=1, CLKS_PER_BIT=16 → 8 `shift` pulses at cycles 26..138; `data_out`=0xA5, `out_parity_err`=0, `out_valid` high at cycle 171.
- Same frame with parity bit 0 → `data_out`=0xA5, `out_parity_err`=1; `framing_error` stays 0.
- 0x3C with stop bit 0, then line held low 40 bit-times → one `framing_error` pulse at cycle 170, no `out_valid`, `busy` high until the line returns high, then IDLE.
- Low glitch of 4 clocks on an idle line → no strobes, `busy` falls after the start check, no flags.
- Two back-to-back frames 0x11 then 0x22 with `out_ready`=0 → first byte held, `overrun` pulse at the second stop sample, `data_out` still 0x11.
- `reset` asserted in the middle of the DATA state → all outputs 0 immediately; the next full frame 0x5A is received correctly.
